// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a word-wide RAM. Sub-word
// stores read-modify-write; loads return the selected lane, extended.
module mem_access_unit #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_bad;

    function automatic logic [31:0] merge_word(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        case (size)
            2'd0:    m[{lane, 3'b000} +: 8]        = data[7:0];
            2'd1:    m[{lane[1], 4'b0000} +: 16]   = data[15:0];
            default: m = data;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        uns,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        req_bad = (req_size == 2'd3)
               || ((req_size == 2'd1) && req_addr[0])
               || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
               || (req_addr >= 32'(ADDR_LIMIT));
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad) begin
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else if (req_we && (req_size == 2'd2)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Sub-word stores reuse wdata_q to hold the merged word.
                if (we_q) begin
                    wdata_d = merge_word(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                    state_d = WRITE;
                end else begin
                    rdata_d = extract_load(mem_rdata, size_q, uns_q, addr_q[1:0]);
                    state_d = RESP;
                end
            end
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses against a
// byte-array reference memory and a word RAM model attached to the DUT.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_we;

    logic [31:0] ram [0:63];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    logic [7:0]  ref_bytes [0:255];
    logic [31:0] last_rdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_access_unit #(.ADDR_LIMIT(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (poke_en)     ram[poke_idx] <= poke_val;
        else if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 6'(idx);
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = val[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        err;
        int          nb, exp_lat, exp_wat, n, we_cnt, we_at;
        logic [31:0] val, exp_wword;
        logic        seen, stray_err;
        err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 256);
        nb  = 1 << sz;
        exp_lat = err ? 1 : ((!we || sz == 2'd2) ? 2 : 3);
        exp_wat = (sz == 2'd2) ? 1 : 2;
        exp_wword = 32'd0;
        if (err) begin
            last_rdata = 32'd0;
        end else if (!we) begin
            val = 32'd0;
            for (int i = 0; i < nb; i++) val = val | (32'(ref_bytes[a+i]) << (8*i));
            if (!uns && nb < 4 && val[8*nb-1]) val = val - (32'd1 << (8*nb));
            last_rdata = val;
        end else begin
            for (int i = 0; i < nb; i++) ref_bytes[a+i] = wd[8*i +: 8];
            exp_wword = ref_word(int'(a / 4));
        end

        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom;
        n = 0; seen = 1'b0; stray_err = 1'b0; we_cnt = 0; we_at = 0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
            if (mem_we) begin
                we_cnt++;
                we_at = n;
                chk({tag, " mem_wdata"}, mem_wdata, exp_wword);
            end
            if (rsp_valid) seen = 1'b1;
            else if (rsp_err) stray_err = 1'b1;
        end
        chk({tag, " rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
        chk({tag, " rsp_rdata"}, rsp_rdata, last_rdata);
        chk({tag, " we_count"}, 32'(we_cnt), (we && !err) ? 32'd1 : 32'd0);
        if (we_cnt > 0) chk({tag, " we_cycle"}, 32'(we_at), 32'(exp_wat));
        @(negedge clk);
        chk({tag, " valid_pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " err_idle"}, {31'd0, rsp_err | stray_err}, 32'd0);
        if (!err) chk({tag, " ram_word"}, ram[a[7:2]], ref_word(int'(a[7:2])));
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          stray;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        last_rdata = 32'd0;
        #1;
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) poke(i, $urandom);

        poke(1, 32'h8081_82F3);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, "lb_signed");
        chk("lb_signed value", rsp_rdata, 32'hFFFF_FFF3);
        do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, "lbu");
        chk("lbu value", rsp_rdata, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lh_signed");

        poke(2, 32'h1122_3344);
        do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_BEEF, "sh");
        chk("sh ram2", ram[2], 32'hBEEF_3344);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw");
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw");
        chk("lw value", rsp_rdata, 32'hDEAD_BEEF);

        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, "err_lw_mis");
        do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, "err_lh_mis");
        do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, "err_size");
        do_req(1'b1, 2'd0, 1'b0, 32'h100, 32'h55, "err_limit");
        do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'h1234_5678, "err_sw_mis");
        do_req(1'b0, 2'd0, 1'b1, 32'hFF, 32'h0, "lbu_top");

        for (int k = 0; k < 60; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 279));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $sformatf("rnd%0d", k));
        end

        poke(2, 32'h5566_7788);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        last_rdata = 32'd0;
        #1;
        chk("arst mem_we", 32'(mem_we), 32'd0);
        chk("arst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst ready", 32'(req_ready), 32'd1);
        chk("arst mem_addr", mem_addr, 32'd0);
        chk("arst rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) stray++;
        end
        chk("arst no_activity", 32'(stray), 32'd0);
        chk("arst ram2", ram[2], 32'h5566_7788);
        chk("arst ready_after", 32'(req_ready), 32'd1);

        do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, "post_rst_lbu");
        for (int i = 0; i < 64; i++) chk($sformatf("final ram%0d", i), ram[i], ref_word(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
